// File: rtl/word_packer.sv
// Packs RATIO narrow words into one wide beat with per-lane keep bits.
// A packet end flushes a partial beat, so no beat ever spans two packets.
module word_packer #(
  parameter int WORD_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [WORD_WIDTH-1:0]       i_data,
  input  logic                        i_last,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [WORD_WIDTH*RATIO-1:0] o_data,
  output logic [RATIO-1:0]            o_keep,
  output logic                        o_last
);

  localparam int LANE_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BEAT_W  = WORD_WIDTH * RATIO;
  localparam int STAGE_W = WORD_WIDTH * (RATIO - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

  logic [LANE_W-1:0]  lane_r;
  logic [LANE_W-1:0]  lane_nxt_s;
  logic [STAGE_W-1:0] stage_r;
  logic [STAGE_W-1:0] stage_nxt_s;
  logic [BEAT_W-1:0]  stage_ext_s;
  logic [BEAT_W-1:0]  data_r;
  logic [BEAT_W-1:0]  data_nxt_s;
  logic [RATIO-1:0]   keep_r;
  logic [RATIO-1:0]   keep_nxt_s;
  logic               last_r;
  logic               last_nxt_s;
  logic               valid_r;
  logic               valid_nxt_s;
  logic               insert_s;
  logic               remove_s;
  logic               complete_s;

  // Ready ignores the lane counter: any pending, unaccepted beat stalls all inserts.
  assign i_ready     = !valid_r || o_ready;
  assign insert_s    = i_valid && i_ready;
  assign remove_s    = valid_r && o_ready;
  assign complete_s  = insert_s && ((lane_r == LAST_LANE) || i_last);
  // The top lane is never staged; it reads as zero so the lane loop below stays uniform.
  assign stage_ext_s = {{WORD_WIDTH{1'b0}}, stage_r};

  // Staging lanes and lane counter for the beat under construction.
  always_comb begin
    stage_nxt_s = stage_r;
    lane_nxt_s  = lane_r;
    if (complete_s) begin
      lane_nxt_s = {LANE_W{1'b0}};
    end else if (insert_s) begin
      lane_nxt_s = lane_r + LANE_W'(1);
      for (int k = 0; k < RATIO - 1; k++) begin
        if (lane_r == LANE_W'(k)) begin
          stage_nxt_s[k*WORD_WIDTH +: WORD_WIDTH] = i_data;
        end else begin
          stage_nxt_s[k*WORD_WIDTH +: WORD_WIDTH] = stage_r[k*WORD_WIDTH +: WORD_WIDTH];
        end
      end
    end else begin
      lane_nxt_s = lane_r;
    end
  end

  // Output beat assembly: staged lanes below, the new word at lane, zeros above.
  always_comb begin
    data_nxt_s  = data_r;
    keep_nxt_s  = keep_r;
    last_nxt_s  = last_r;
    valid_nxt_s = valid_r;
    if (complete_s) begin
      for (int k = 0; k < RATIO; k++) begin
        if (LANE_W'(k) < lane_r) begin
          data_nxt_s[k*WORD_WIDTH +: WORD_WIDTH] = stage_ext_s[k*WORD_WIDTH +: WORD_WIDTH];
        end else if (LANE_W'(k) == lane_r) begin
          data_nxt_s[k*WORD_WIDTH +: WORD_WIDTH] = i_data;
        end else begin
          data_nxt_s[k*WORD_WIDTH +: WORD_WIDTH] = {WORD_WIDTH{1'b0}};
        end
        keep_nxt_s[k] = (LANE_W'(k) <= lane_r);
      end
      last_nxt_s  = i_last;
      valid_nxt_s = 1'b1;
    end else if (remove_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_r  <= {LANE_W{1'b0}};
      stage_r <= {STAGE_W{1'b0}};
      data_r  <= {BEAT_W{1'b0}};
      keep_r  <= {RATIO{1'b0}};
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      lane_r  <= lane_nxt_s;
      stage_r <= stage_nxt_s;
      data_r  <= data_nxt_s;
      keep_r  <= keep_nxt_s;
      last_r  <= last_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign o_valid = valid_r;
  assign o_data  = data_r;
  assign o_keep  = keep_r;
  assign o_last  = last_r;

endmodule

// File: tb/tb_word_packer.sv
// Directed and random-stall bench for word_packer (WORD_WIDTH=8, RATIO=4)
// with a queue scoreboard fed by a packing model of the accepted words.
module tb_word_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  i_data;
  logic        i_last;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_last;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  int          total = 0;
  int          bad   = 0;
  beat_t       exp_q[$];
  logic [31:0] mdl_data;
  int          mlane;
  beat_t       mon_e;
  beat_t       prev_b;
  logic        stall_q = 1'b0;
  logic        acc;

  always #5 clk = ~clk;

  word_packer #(.WORD_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_keep(o_keep), .o_last(o_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packing model: fill lanes from 0, emit on lane 3 or on last.
  task automatic model_push(input logic [7:0] d, input logic l);
    beat_t b;
    mdl_data[mlane*8 +: 8] = d;
    mlane++;
    if (mlane == 4 || l) begin
      b.data = mdl_data;
      b.keep = 4'((1 << mlane) - 1);
      b.last = l;
      exp_q.push_back(b);
      mdl_data = 32'h0;
      mlane    = 0;
    end
  endtask

  // One clock: drive at posedge+1, see handshake at negedge, return after next posedge+1.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic rdy,
                       output logic a);
    i_valid = v;
    i_data  = d;
    i_last  = l;
    o_ready = rdy;
    @(negedge clk);
    a = v && i_ready;
    @(posedge clk);
    #1;
    if (a) model_push(d, l);
  endtask

  task automatic send_word(input logic [7:0] d, input logic l);
    logic a;
    int   n;
    n = 0;
    a = 1'b0;
    while (!a && n < 50) begin
      cycle(1'b1, d, l, 1'b1, a);
      n++;
    end
    chk("send_accept", a, 1'b1);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, a);
  endtask

  // Output monitor: ready rule, stall stability and scoreboard pop.
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      chk("i_ready_rule", i_ready, !o_valid || o_ready);
      if (stall_q) begin
        chk("stall_valid", o_valid, 1'b1);
        chk("stall_beat", {o_data, o_keep, o_last}, prev_b);
      end
      if (o_valid && o_ready) begin
        chk("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("beat_data", o_data, mon_e.data);
          chk("beat_keep", o_keep, mon_e.keep);
          chk("beat_last", o_last, mon_e.last);
        end
      end
      stall_q = o_valid && !o_ready;
      prev_b  = {o_data, o_keep, o_last};
    end
  end

  initial begin : main
    int          plen;
    int          pos;
    logic [7:0]  nxt;
    logic        have;
    logic [7:0]  cd;
    logic        cl;
    logic        rdy;

    reset = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_last = 1'b0; o_ready = 1'b1;
    mlane = 0; mdl_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_data", o_data, 32'h0);
    chk("rst_o_keep", o_keep, 4'h0);
    chk("rst_o_last", o_last, 1'b0);
    chk("rst_i_ready", i_ready, 1'b1);
    @(posedge clk);
    #1;

    // Two full beats back to back.
    for (int b = 1; b <= 8; b++) send_word(8'(b), b == 8);
    idle(3);
    chk("t1_drain", exp_q.size(), 0);

    // Partial tail beat.
    for (int b = 1; b <= 6; b++) send_word(8'hA0 + 8'(b), b == 6);
    idle(3);
    chk("t2_drain", exp_q.size(), 0);

    // Single-word packet, then next packet starts in lane 0.
    send_word(8'h55, 1'b1);
    send_word(8'hC1, 1'b0);
    send_word(8'hC2, 1'b1);
    idle(3);
    chk("t3_drain", exp_q.size(), 0);

    // Back-pressure, then release together with a completing insert.
    cycle(1'b1, 8'h77, 1'b1, 1'b0, acc);
    chk("bp_first_insert", acc, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h88, 1'b1, 1'b0, acc);
      chk("bp_no_insert", acc, 1'b0);
    end
    cycle(1'b1, 8'h88, 1'b1, 1'b1, acc);
    chk("bp_release_insert", acc, 1'b1);
    chk("bp_no_bubble", o_valid, 1'b1);
    chk("bp_new_data", o_data, 32'h00000088);
    idle(3);
    chk("t4_drain", exp_q.size(), 0);

    // Reset mid-packet discards staged words.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    reset = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mlane = 0;
    mdl_data = 32'h0;
    @(negedge clk);
    chk("mid_rst_o_valid", o_valid, 1'b0);
    chk("mid_rst_o_keep", o_keep, 4'h0);
    @(posedge clk);
    #1;
    for (int b = 3; b <= 6; b++) send_word(8'h30 + 8'(b), b == 6);
    idle(3);
    chk("t5_drain", exp_q.size(), 0);

    // Random stall soak.
    plen = 1; pos = 0; nxt = 8'h00; have = 1'b0; cd = 8'h00; cl = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        if (pos == 0) plen = $urandom_range(1, 13);
        cd   = nxt;
        cl   = (pos + 1 == plen);
        have = 1'b1;
      end
      rdy = ($urandom_range(0, 3) != 0);
      cycle(have, cd, cl, rdy, acc);
      if (acc) begin
        have = 1'b0;
        nxt  = nxt + 8'd1;
        pos  = cl ? 0 : pos + 1;
      end
    end
    if (have) begin
      send_word(cd, cl);
      nxt = nxt + 8'd1;
      pos = cl ? 0 : pos + 1;
    end
    while (pos != 0) begin
      cl = (pos + 1 == plen);
      send_word(nxt, cl);
      nxt = nxt + 8'd1;
      pos = cl ? 0 : pos + 1;
    end
    idle(5);
    chk("soak_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_packer.md
# word_packer

Upstream neighbour of the skid buffer in the MM2S datapath. It accepts a stream of narrow words with an end-of-packet flag and packs RATIO consecutive words into one wide beat with per-lane keep bits. The wide beat is presented on a registered valid/ready output, normally consumed by a skid buffer of width WORD_WIDTH*RATIO+RATIO+1. A packet end forces out a partial beat, so packets never share a beat.

## Interface
- WORD_WIDTH, 8: width of one input word.
- RATIO, 4: input words per output beat; must be ≥2. Lane index width is $clog2(RATIO).
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state on the next posedge.
- i_valid  in  1  input word valid.
- i_ready  out  1  packer can accept the input word this cycle.
- i_data  in  WORD_WIDTH  input word.
- i_last  in  1  this word ends a packet; qualified by i_valid.
- o_valid  out  1  wide beat valid (registered).
- o_ready  in  1  downstream accepts the beat.
- o_data  out  WORD_WIDTH*RATIO  packed beat; first word of the beat in lane 0, bits [WORD_WIDTH-1:0].
- o_keep  out  RATIO  lane k holds valid data when bit k=1; always a contiguous run from bit 0.
- o_last  out  1  beat ends a packet.

## Operation
- insert = i_valid && i_ready; remove = o_valid && o_ready.
- i_ready = !o_valid || o_ready. This is a combinational path from o_ready, which is legal because the downstream skid buffer registers its ready. i_ready does not depend on i_valid, i_data or i_last.
- Staging: RATIO-1 lane registers plus a lane counter `lane` (0..RATIO-1). Lane registers hold words of the current, incomplete beat.
- On insert, the word is "completing" when lane==RATIO-1 or i_last==1.
  - Non-completing: write i_data into staging lane `lane`, then lane←lane+1. The output register is untouched.
  - Completing: load the output register in the same edge.
    - o_data = staged lanes 0..lane-1, plus i_data in lane `lane`, plus zeros in all higher lanes.
    - o_keep = (1<<(lane+1))-1.
    - o_last = i_last; o_valid←1.
    - lane←0. Staging contents are don't-care after a completing insert; the zero fill of higher lanes is taken from constants, not from stale staging.
- If remove happens with no completing insert, o_valid←0. o_data, o_keep and o_last hold their values; they are don't-care while o_valid=0.
- If remove and a completing insert happen in the same cycle, the output register reloads with the new beat and o_valid stays 1. This gives no bubble.
- A non-completing insert is never blocked by a pending beat beyond the i_ready rule above.
- lane wraps only via a completing insert; lane never exceeds RATIO-1.
- Protocol requirements on the upstream side: once i_valid rises it stays high, with i_data and i_last stable, until insert.
- Protocol guarantees on the downstream side: while o_valid && !o_ready, o_valid, o_data, o_keep and o_last are stable.

## Timing
- Reset values:
  - o_valid=0, o_data=0, o_keep=0, o_last=0.
  - lane=0; staging lanes =0.
  - i_ready reads 1 in the first cycle after reset.
- Reset mid-packet discards the staged words and any pending beat. The first word after reset lands in lane 0.
- Latency: a completing insert at edge N gives o_valid=1 after edge N.
- Throughput: one input word per cycle sustained while o_ready=1. Output is one beat per RATIO input cycles for full beats. A packet of length RATIO*k+1 emits a 1-lane tail beat.
- Back-pressure: with o_valid=1 and o_ready=0, i_ready=0 on that cycle. This stalls all inserts, including non-completing ones. The rule keeps the i_ready logic free of the lane counter.

## Test plan
- WORD_WIDTH=8, RATIO=4, o_ready=1: send 0x01..0x08 back-to-back with i_last only on 0x08. Expect two beats: o_data=0x04030201, o_keep=0xF, o_last=0; then o_data=0x08070605, o_keep=0xF, o_last=1. Expect i_ready=1 throughout.
- Partial tail: send 0xA1,0xA2,0xA3,0xA4,0xA5,0xA6 with i_last on 0xA6. Expect a second beat o_data=0x0000A6A5, o_keep=0x3, o_last=1, with the upper lanes zero.
- Single-word packet: send 0x55 with i_last=1. Expect one cycle later o_data=0x00000055, o_keep=0x1, o_last=1, then the next packet starts in lane 0.
- Back-pressure: hold o_ready=0 while a beat is pending. Check that o_* stay stable and i_ready=0 for 5 cycles. Release o_ready; in the same cycle a completing word is inserted; o_valid stays 1 and the new beat appears on the next edge with no bubble.
- Reset mid-packet: insert 0x11,0x22, assert reset for 1 cycle, then send 0x33..0x36 with i_last on 0x36. Expect only o_data=0x36353433, o_keep=0xF, o_last=1. Expect o_valid=0 and o_keep=0 immediately after reset.
- Random stall soak: randomise i_valid and o_ready over 10k cycles with random packet lengths 1–13. A scoreboard checks byte order, keep and last, and checks output stability under stall.
